mem_line_ctrl: RTL

//  Sequences whole cache-line fills and writebacks over the byte-wide main-memory port.
//  - Main-memory port: mem_addr / mem_wdata / mem_we / mem_rdata.
//  - Accepts one line request at a time from the cache controller.
//  - Issues LINE_BYTES byte accesses, each held for WAIT_CYCLES+1 cycles.
//  - Assembles read bytes into a line and returns it via a valid/ready response.

---
 rtl/mem_ctrl_pkg.sv | 21 ++
 rtl/mem_wait_timer.sv | 32 +++
 rtl/mem_line_ctrl.sv | 139 +++++++++++++
 3 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared types for the line fill / writeback sequencer.
// States, op encodings and a constant-width helper.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  localparam logic OP_FILL = 1'b0;
  localparam logic OP_WB   = 1'b1;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Per-byte wait counter: load restarts the count, done marks
// the last cycle a byte address is held (always 1 for zero waits).
module mem_wait_timer
  import mem_ctrl_pkg::*;
#(
  parameter int WAIT_CYCLES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  output logic done
);

  localparam int CW =
    (WAIT_CYCLES > 0) ? clog2(WAIT_CYCLES + 1) : 1;

  logic [CW-1:0] count;

  // reload on byte start, otherwise count down to zero
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= CW'(WAIT_CYCLES);
    end else if (count != '0) begin
      count <= count - CW'(1);
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/mem_line_ctrl.sv
// Cache-line fill / writeback sequencer over a byte-wide memory port.
// Optional MEM_LINE_CTRL_PERF_EN adds fill / writeback counters.
module mem_line_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int LINE_BYTES  = 4,
  parameter int WAIT_CYCLES = 2,
  localparam int LINE_W     = 8 * LINE_BYTES
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [LINE_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [LINE_W-1:0] resp_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              mem_we,
  input  logic [7:0]        mem_rdata,
  output logic              busy
`ifdef MEM_LINE_CTRL_PERF_EN
  ,
  output logic [15:0]       perf_fills,
  output logic [15:0]       perf_wbs
`endif
);

  localparam int IDX_W =
    (LINE_BYTES > 1) ? clog2(LINE_BYTES) : 1;
  localparam logic [ADDR_W-1:0] ALIGN_MASK =
    ~(ADDR_W'(LINE_BYTES) - ADDR_W'(1));
  localparam logic [IDX_W-1:0] LAST_IDX =
    IDX_W'(LINE_BYTES - 1);

  state_t              state;
  state_t              state_nxt;
  logic                op;
  logic [ADDR_W-1:0]   base;
  logic [LINE_W-1:0]   wdata_q;
  logic [IDX_W-1:0]    idx;
  logic [IDX_W-1:0]    idx_nxt;
  logic                done;
  logic                accept;
  logic                step;
  logic                last;
  logic                hs;

  assign req_ready  = (state == IDLE);
  assign busy       = (state != IDLE);
  assign resp_valid = (state == RESP);
  assign accept     = req_valid && req_ready;
  assign step       = (state == ACCESS) && done;
  assign last       = step && (idx == LAST_IDX);
  assign hs         = resp_valid && resp_ready;
  assign idx_nxt    = idx + IDX_W'(1);

  mem_wait_timer #(
    .WAIT_CYCLES (WAIT_CYCLES)
  ) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (accept || step),
    .done  (done)
  );

  // state register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // next-state decode
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept)     state_nxt = ACCESS;
      ACCESS:  if (last)       state_nxt = RESP;
      RESP:    if (resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // request latch, byte walk and fill assembly
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op         <= OP_FILL;
      base       <= '0;
      wdata_q    <= '0;
      idx        <= '0;
      resp_rdata <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_we     <= 1'b0;
    end else if (accept) begin
      op         <= req_write;
      base       <= req_addr & ALIGN_MASK;
      wdata_q    <= req_wdata;
      idx        <= '0;
      resp_rdata <= '0;
      mem_addr   <= req_addr & ALIGN_MASK;
      mem_wdata  <= req_wdata[7:0];
      mem_we     <= req_write;
    end else if (step) begin
      if (op == OP_FILL)
        resp_rdata[idx*8 +: 8] <= mem_rdata;
      if (last) begin
        mem_we <= 1'b0;
      end else begin
        idx       <= idx_nxt;
        mem_addr  <= base + ADDR_W'(idx_nxt);
        mem_wdata <= wdata_q[idx_nxt*8 +: 8];
      end
    end
  end

`ifdef MEM_LINE_CTRL_PERF_EN
  // saturating completion counters per op type
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_fills <= '0;
      perf_wbs   <= '0;
    end else if (hs) begin
      if (op == OP_FILL && perf_fills != 16'hFFFF)
        perf_fills <= perf_fills + 16'd1;
      if (op == OP_WB && perf_wbs != 16'hFFFF)
        perf_wbs <= perf_wbs + 16'd1;
    end
  end
`else
  logic unused_hs;
  assign unused_hs = hs;
`endif

endmodule
